insn_sequencer: RTL
===================

// Module: insn_sequencer
// PURPOSE
//   Multi-cycle control FSM for the RV32 core. Fetches one instruction at a time over a
//   req/ready instruction port and holds it in an instruction register that drives the
//   decoder. Consumes the decoder's controls and sequences the data-memory access,
//   register-file write and PC update. Sits between the memory ports, the decoder, the
//   ALU/register file and the PC.
// PARAMETERS
//   ADDR_W    32     width of pc / imem_addr / branch_target
//   RESET_PC  32'h0  pc value after reset
//   TIMEOUT   255    max cycles a memory request may wait for ready before entering FAULT
// PORTS
//   clk            in   1       core clock
//   rst            in   1       synchronous, active-high reset
//   run            in   1       1 = allow new fetches; 0 = stall at next FETCH
//   imem_req       out  1       instruction fetch request
//   imem_addr      out  ADDR_W  fetch address (= pc)
//   imem_ready     in   1       fetch completes on the cycle imem_req && imem_ready
//   imem_rdata     in   32      instruction word, valid when imem_ready
//   insn           out  32      instruction register, feeds decoder `instruction input
//   dec_reg_we     in   1       decoder registerWriteEnable
//   dec_data_we    in   1       decoder dataWriteEnable (store)
//   dec_branch     in   1       decoder branchCtr
//   dec_load       in   1       decoder load indication
//   alu_zero       in   1       ALU zero flag, valid in EXEC
//   branch_target  in   ADDR_W  computed branch target, valid in EXEC
//   dmem_req       out  1       data memory request
//   dmem_we        out  1       1 = store, 0 = load; valid with dmem_req
//   dmem_ready     in   1       data access completes on dmem_req && dmem_ready
//   rf_we          out  1       register-file write strobe, 1-cycle pulse in WB
//   pc             out  ADDR_W  current program counter
//   retire         out  1       1-cycle pulse when an instruction completes
//   fault          out  1       sticky error flag
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge): state=FETCH, pc=RESET_PC, insn=32'h0, all strobes/req=0,
//     fault=0, timeout counter=0. Reset mid-operation aborts the instruction; requests drop
//     on the same edge; no rf_we or retire is produced.
//   States: FETCH, DECODE, EXEC, MEM, WB, FAULT.
//   FETCH: imem_req=run. On imem_req&&imem_ready: insn<=imem_rdata -> DECODE.
//     run=0 holds FETCH with imem_req=0; run is ignored in every other state.
//   DECODE: 1 cycle; the decoder settles on insn -> EXEC.
//   EXEC: register dec_* controls, alu_zero and branch_target. (dec_load|dec_data_we) -> MEM,
//     else -> WB. If dec_branch&&alu_zero&&branch_target[1:0]!=0 -> FAULT.
//   MEM: dmem_req=1, dmem_we=registered dec_data_we, held stable until dmem_ready -> WB.
//     dec_load&&dec_data_we together: treated as store.
//   WB: rf_we=registered dec_reg_we (1 cycle); retire=1;
//     pc<=(branch&&zero)?branch_target:pc+4, mod 2^ADDR_W (wrap to 0, no fault) -> FETCH.
//   Latency: non-memory insn with zero-wait fetch = 4 cycles (FETCH..WB); load/store >= 5.
//   Unrecognised encoding (all dec_* = 0): executes as NOP, pc+4, retire=1, rf_we=0.
//   Timeout: counter clears on entry to FETCH/MEM and counts each cycle req=1 && ready=0;
//     reaching TIMEOUT -> FAULT. run=0 does not count.
//   FAULT: all req/strobes=0, fault=1, pc frozen; leaves only on rst.
// STRUCTURE
//   State encoding and the `INSN_NOP constant go in Types.v alongside `instruction/`ctrALU.
//   Single module; no sub-module is warranted. The timeout counter is $clog2(TIMEOUT+1) bits.
// TESTING
//   rst, run=1, zero-wait memories, add insn -> imem_req at cycle 0; rf_we and retire in
//     cycle 3; pc 0->4.
//   lw with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 held 4 cycles; rf_we once;
//     retire at cycle 7.
//   sw -> dmem_we=1 during MEM, rf_we=0 in WB, pc+4.
//   branch, alu_zero=1, target 32'h40 -> pc=32'h40; target 32'h42 -> fault=1,
//     no further imem_req.
//   pc=32'hFFFFFFFC with a NOP -> pc wraps to 0; retire=1.
//   imem_ready held 0 for TIMEOUT cycles -> fault; rst mid-MEM -> next cycle FETCH,
//     pc=RESET_PC, no rf_we.

Source files
------------

// File: rtl/insn_sequencer_pkg.sv
// Shared types for the multi-cycle instruction sequencer: FSM state encoding and the canonical NOP word.
package insn_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

endpackage

// File: rtl/insn_sequencer.sv
// Multi-cycle RV32 control FSM: FETCH->DECODE->EXEC->[MEM]->WB, 4 cycles min, >=5 with a memory access.
// Waits on imem/dmem ready with a bounded timeout into a sticky FAULT; run=0 parks the sequencer in FETCH.
module insn_sequencer
  import insn_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       insn,
  input  logic              dec_reg_we,
  input  logic              dec_data_we,
  input  logic              dec_branch,
  input  logic              dec_load,
  input  logic              alu_zero,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [31:0]       insn_q, insn_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              reg_we_q, reg_we_d;
  logic              data_we_q, data_we_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cnt_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      insn_q    <= '0;
      pc_q      <= RESET_PC;
      target_q  <= '0;
      reg_we_q  <= 1'b0;
      data_we_q <= 1'b0;
      taken_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      insn_q    <= insn_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      reg_we_q  <= reg_we_d;
      data_we_q <= data_we_d;
      taken_q   <= taken_d;
      cnt_q     <= cnt_d;
    end
  end

  // Counter only advances on a stalled request, so cnt_q never exceeds TIMEOUT-1.
  assign cnt_inc     = cnt_q + 1'b1;
  assign cnt_expired = (cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    insn_d    = insn_q;
    pc_d      = pc_q;
    target_d  = target_q;
    reg_we_d  = reg_we_q;
    data_we_d = data_we_q;
    taken_d   = taken_q;
    cnt_d     = '0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    retire    = 1'b0;
    fault     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = run;
        if (!run) begin
          cnt_d = cnt_q;
        end else if (imem_ready) begin
          insn_d  = imem_rdata;
          state_d = ST_DECODE;
        end else if (cnt_expired) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        reg_we_d  = dec_reg_we;
        data_we_d = dec_data_we;
        taken_d   = dec_branch && alu_zero;
        target_d  = branch_target;
        if (dec_branch && alu_zero && (branch_target[1:0] != 2'b00)) begin
          state_d = ST_FAULT;
        end else if (dec_load || dec_data_we) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // A combined load+store flag set falls out as a store via data_we_q.
        dmem_req = 1'b1;
        dmem_we  = data_we_q;
        if (dmem_ready) begin
          state_d = ST_WB;
        end else if (cnt_expired) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WB: begin
        rf_we   = reg_we_q;
        retire  = 1'b1;
        pc_d    = taken_q ? target_q : pc_q + ADDR_W'(4);
        state_d = ST_FETCH;
      end
      ST_FAULT: fault = 1'b1;
      default:  state_d = ST_FAULT;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign insn      = insn_q;

endmodule
